// File: rtl/sdp_seq_ctrl.sv
// -----------------------------------------------------------------------------
// sdp_seq_ctrl -- read/write sequencer for a chunked simple-dual-port buffer.
//
// Read side: a descriptor (base chunk, chunks per pass, pass count) is accepted
// in IDLE. RUN then walks the chunks pass by pass, loading the buffer read
// pointer at the first chunk of each pass and incrementing it for the others.
// The buffer wraps its pointer at NUM_CHUNKS-1, so base+len may run past the
// end of the buffer. Read beats come out one cycle after the issue, aligned
// with the buffer rdata. DRAIN waits for the final beat to be taken and
// pulses done.
//
// Write side: independent of the read FSM. Counts write words modulo
// READ_WIDTH_MUL and, at the producer's layer end, asks the buffer to skip to
// the next chunk if the current chunk is only partly filled.
//
// Handshakes: a transfer happens in a cycle where valid and ready are both
// high at the rising clock edge; valid, once raised, holds its payload
// steady until that edge.
//
// Optional feature: define SDP_SEQ_CTRL_CHECK_EN to reject illegal
// descriptors (cfg_len == 0, cfg_len > NUM_CHUNKS, cfg_passes == 0) with a
// one-cycle cfg_err pulse. Without it cfg_err is tied low.
//
// Ports:
//   clk, rst          clock, asynchronous active-high reset
//   cfg_valid/ready   descriptor handshake (ready only in IDLE)
//   cfg_base          first chunk of the layer
//   cfg_len           chunks per pass (1..NUM_CHUNKS)
//   cfg_passes        passes over the chunks (>= 1)
//   cfg_err           illegal-descriptor pulse
//   rp_load           load buffer read pointer with rp_load_val
//   rp_load_val       read pointer load value (the latched base)
//   rp_inc            advance buffer read pointer
//   rd_valid/ready    read beat handshake towards the consumer
//   rd_first/last     beat is the first / last chunk of a pass
//   done              one-cycle pulse when the last beat of the layer is taken
//   wr_valid          producer word valid
//   wr_layer_end      producer finished the layer
//   we                buffer write enable
//   w_next_chunk      buffer skips to the next write chunk
//   dbg_state         current FSM state (debug visibility)
// -----------------------------------------------------------------------------
module sdp_seq_ctrl #(
    parameter int NUM_CHUNKS     = 35,
    parameter int READ_WIDTH_MUL = 27,
    parameter int PASS_W         = 16,
    localparam int CW = (NUM_CHUNKS > 1) ? $clog2(NUM_CHUNKS) : 1,
    localparam int WW = (READ_WIDTH_MUL > 1) ? $clog2(READ_WIDTH_MUL) : 1
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              cfg_valid,
    output logic              cfg_ready,
    input  logic [CW-1:0]     cfg_base,
    input  logic [CW:0]       cfg_len,
    input  logic [PASS_W-1:0] cfg_passes,
    output logic              cfg_err,
    output logic              rp_load,
    output logic [CW-1:0]     rp_load_val,
    output logic              rp_inc,
    output logic              rd_valid,
    input  logic              rd_ready,
    output logic              rd_first,
    output logic              rd_last,
    output logic              done,
    input  logic              wr_valid,
    input  logic              wr_layer_end,
    output logic              we,
    output logic              w_next_chunk,
    output logic [1:0]        dbg_state
);

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_RUN   = 2'd1,
        ST_DRAIN = 2'd2
    } state_e;

    localparam logic [WW-1:0] WO_MAX = WW'(READ_WIDTH_MUL - 1);

    state_e              state_q, state_d;
    logic [CW-1:0]       base_q, base_d;
    logic [CW:0]         len_q, len_d;
    logic [PASS_W-1:0]   passes_q, passes_d;
    logic [CW-1:0]       ci_q, ci_d;
    logic [PASS_W-1:0]   pi_q, pi_d;
    logic                rd_valid_q, rd_valid_d;
    logic                rd_first_q, rd_first_d;
    logic                rd_last_q, rd_last_d;
    logic [WW-1:0]       wo_q, wo_d;

    logic                issue;
    logic                ci_last;
    logic                pi_last;
    logic                cfg_bad;
    logic [WW-1:0]       wo_after;

`ifdef SDP_SEQ_CTRL_CHECK_EN
    assign cfg_bad = (cfg_len == '0) ||
                     (cfg_len > (CW+1)'(NUM_CHUNKS)) ||
                     (cfg_passes == '0);
`else
    // Illegal descriptors are not screened in this build.
    assign cfg_bad = 1'b0;
`endif

    assign ci_last = ({1'b0, ci_q} == (len_q - 1'b1));
    assign pi_last = (pi_q == (passes_q - 1'b1));

    // ------------------------------------------------------------------
    // Read FSM: next state and outputs
    // ------------------------------------------------------------------
    always_comb begin
        state_d    = state_q;
        base_d     = base_q;
        len_d      = len_q;
        passes_d   = passes_q;
        ci_d       = ci_q;
        pi_d       = pi_q;
        cfg_ready  = 1'b0;
        cfg_err    = 1'b0;
        issue      = 1'b0;
        done       = 1'b0;

        case (state_q)
            ST_IDLE: begin
                cfg_ready = 1'b1;
                if (cfg_valid) begin
                    if (cfg_bad) begin
                        cfg_err = 1'b1;
                    end else begin
                        base_d   = cfg_base;
                        len_d    = cfg_len;
                        passes_d = cfg_passes;
                        ci_d     = '0;
                        pi_d     = '0;
                        state_d  = ST_RUN;
                    end
                end
            end

            ST_RUN: begin
                // The output register is free when empty or being emptied.
                issue = !rd_valid_q || rd_ready;
                if (issue) begin
                    if (ci_last) begin
                        ci_d = '0;
                        pi_d = pi_q + 1'b1;
                        if (pi_last) begin
                            state_d = ST_DRAIN;
                        end
                    end else begin
                        ci_d = ci_q + 1'b1;
                    end
                end
            end

            ST_DRAIN: begin
                // Only the final beat can still be held in the output register.
                if (rd_valid_q && rd_ready) begin
                    done    = 1'b1;
                    state_d = ST_IDLE;
                end
            end

            default: begin
                state_d = ST_IDLE;
            end
        endcase
    end

    // Beat register: mirrors the buffer's one-cycle read latency.
    always_comb begin
        rd_valid_d = rd_valid_q;
        rd_first_d = rd_first_q;
        rd_last_d  = rd_last_q;
        if (issue) begin
            rd_valid_d = 1'b1;
            rd_first_d = (ci_q == '0);
            rd_last_d  = ci_last;
        end else if (rd_ready) begin
            rd_valid_d = 1'b0;
            rd_first_d = 1'b0;
            rd_last_d  = 1'b0;
        end
    end

    assign rp_load     = issue && (ci_q == '0);
    assign rp_inc      = issue && (ci_q != '0);
    assign rp_load_val = base_q;
    assign rd_valid    = rd_valid_q;
    assign rd_first    = rd_first_q;
    assign rd_last     = rd_last_q;
    assign dbg_state   = state_q;

    // ------------------------------------------------------------------
    // Write side
    // ------------------------------------------------------------------
    assign we = wr_valid;

    always_comb begin
        wo_after = wo_q;
        if (wr_valid) begin
            wo_after = (wo_q == WO_MAX) ? '0 : wo_q + 1'b1;
        end
        // A partly filled chunk is closed at layer end; a full one already
        // wrapped to offset 0 and needs no skip.
        w_next_chunk = wr_layer_end && (wo_after != '0);
        wo_d         = w_next_chunk ? '0 : wo_after;
    end

    // ------------------------------------------------------------------
    // Registers
    // ------------------------------------------------------------------
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q    <= ST_IDLE;
            base_q     <= '0;
            len_q      <= '0;
            passes_q   <= '0;
            ci_q       <= '0;
            pi_q       <= '0;
            rd_valid_q <= 1'b0;
            rd_first_q <= 1'b0;
            rd_last_q  <= 1'b0;
            wo_q       <= '0;
        end else begin
            state_q    <= state_d;
            base_q     <= base_d;
            len_q      <= len_d;
            passes_q   <= passes_d;
            ci_q       <= ci_d;
            pi_q       <= pi_d;
            rd_valid_q <= rd_valid_d;
            rd_first_q <= rd_first_d;
            rd_last_q  <= rd_last_d;
            wo_q       <= wo_d;
        end
    end

endmodule

// File: tb/tb_sdp_seq_ctrl.sv
// Testbench for sdp_seq_ctrl: directed scenarios plus randomized layers and
// write traffic, checked against a chunk-list model of the read sequence, a
// model of the attached buffer's read pointer, and a modulo word counter.
module tb_sdp_seq_ctrl;

  localparam int NUM = 35;
  localparam int RWM = 27;
  localparam int PW  = 16;
  localparam int CW  = $clog2(NUM);

  logic          clk = 1'b0;
  logic          rst;
  logic          cfg_valid;
  logic          cfg_ready;
  logic [CW-1:0] cfg_base;
  logic [CW:0]   cfg_len;
  logic [PW-1:0] cfg_passes;
  logic          cfg_err;
  logic          rp_load;
  logic [CW-1:0] rp_load_val;
  logic          rp_inc;
  logic          rd_valid;
  logic          rd_ready;
  logic          rd_first;
  logic          rd_last;
  logic          done;
  logic          wr_valid;
  logic          wr_layer_end;
  logic          we;
  logic          w_next_chunk;
  logic [1:0]    dbg_state;

  sdp_seq_ctrl #(
    .NUM_CHUNKS    (NUM),
    .READ_WIDTH_MUL(RWM),
    .PASS_W        (PW)
  ) dut (
    .clk         (clk),
    .rst         (rst),
    .cfg_valid   (cfg_valid),
    .cfg_ready   (cfg_ready),
    .cfg_base    (cfg_base),
    .cfg_len     (cfg_len),
    .cfg_passes  (cfg_passes),
    .cfg_err     (cfg_err),
    .rp_load     (rp_load),
    .rp_load_val (rp_load_val),
    .rp_inc      (rp_inc),
    .rd_valid    (rd_valid),
    .rd_ready    (rd_ready),
    .rd_first    (rd_first),
    .rd_last     (rd_last),
    .done        (done),
    .wr_valid    (wr_valid),
    .wr_layer_end(wr_layer_end),
    .we          (we),
    .w_next_chunk(w_next_chunk),
    .dbg_state   (dbg_state)
  );

  // ---------------- clock ----------------
  always #5 clk = ~clk;

  // ---------------- scoreboard state ----------------
  logic [CW+1:0] exp_q[$];   // expected beats {first, last, chunk}
  logic [CW:0]   iss_q[$];   // expected issues {is_load, chunk}
  int n_tests = 0;
  int n_fail  = 0;
  int cyc = 0;
  int hs_cyc = 0;
  int first_rv_cyc = 0;
  int done_cyc = 0;
  int n_load = 0;
  int n_inc = 0;
  int n_stall = 0;
  int rr_mode = 1;           // 0: rd_ready low, 1: high, 2: random
  bit layer_done = 0;
  bit seen_first_rv = 0;
  bit cur_illegal = 0;
  logic [CW-1:0] ptr_m = '0;      // buffer read pointer model
  logic [CW-1:0] rdchunk_m = '0;  // chunk currently on buffer rdata
  int wo_m = 0;
  bit prev_stall = 0;
  logic prev_first = 0;
  logic prev_last = 0;
  logic [1:0] idle_code;

  // monitor temporaries
  logic [CW+1:0] m_beat;
  logic [CW-1:0] m_ptr;
  bit  m_exp_done;
  int  m_wo_after;
  bit  m_exp_nc;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_tests++;
    if (obs !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h (cycle %0d)", tag, obs, exp, cyc);
    end
  endtask

  // ---------------- rd_ready driver ----------------
  initial begin
    rd_ready = 1'b0;
    forever begin
      @(posedge clk);
      #1;
      case (rr_mode)
        0:       rd_ready = 1'b0;
        1:       rd_ready = 1'b1;
        default: rd_ready = 1'($urandom_range(0, 1));
      endcase
    end
  end

  // ---------------- monitor / scoreboard ----------------
  always @(negedge clk) begin
    cyc++;
    if (rst) begin
      prev_stall = 0;
    end else begin
      if (cfg_valid && cfg_ready) begin
        hs_cyc = cyc;
        seen_first_rv = 0;
        check("cfg_err_on_handshake", cfg_err, cur_illegal);
      end else if (cfg_err) begin
        check("cfg_err_spurious", cfg_err, 0);
      end

      if (rd_valid && !seen_first_rv) begin
        first_rv_cyc = cyc;
        seen_first_rv = 1;
      end

      if (prev_stall) begin
        check("stall_valid_held", rd_valid, 1);
        check("stall_flags_held", {rd_first, rd_last}, {prev_first, prev_last});
      end
      if (rd_valid && !rd_ready) begin
        n_stall++;
        check("stall_no_issue", {rp_load, rp_inc}, 2'b00);
      end
      prev_stall = rd_valid && !rd_ready;
      prev_first = rd_first;
      prev_last  = rd_last;

      m_exp_done = 0;
      if (rd_valid && rd_ready) begin
        check("beat_expected", exp_q.size() != 0, 1);
        if (exp_q.size() != 0) begin
          m_beat = exp_q.pop_front();
          check("beat", {rd_first, rd_last, rdchunk_m}, m_beat);
          if (exp_q.size() == 0) m_exp_done = 1;
        end
      end
      if (done || m_exp_done) begin
        check("done", done, m_exp_done);
        if (m_exp_done) begin
          layer_done = 1;
          done_cyc = cyc;
        end
      end

      if (rp_load || rp_inc) begin
        check("load_inc_exclusive", rp_load & rp_inc, 0);
        if (rp_load) n_load++;
        else         n_inc++;
        m_ptr = rp_load ? rp_load_val
                        : ((ptr_m == CW'(NUM - 1)) ? '0 : ptr_m + 1'b1);
        check("issue_expected", iss_q.size() != 0, 1);
        if (iss_q.size() != 0) check("issue", {rp_load, m_ptr}, iss_q.pop_front());
        ptr_m = m_ptr;
        rdchunk_m = m_ptr;
      end

      if (wr_valid || wr_layer_end) begin
        check("we", we, wr_valid);
        m_wo_after = wr_valid ? (wo_m + 1) % RWM : wo_m;
        m_exp_nc = wr_layer_end && (m_wo_after != 0);
        check("w_next_chunk", w_next_chunk, m_exp_nc);
        wo_m = m_exp_nc ? 0 : m_wo_after;
      end else if (w_next_chunk || we) begin
        check("write_side_idle", {we, w_next_chunk}, 2'b00);
      end
    end
  end

  // ---------------- driver tasks ----------------
  task automatic wait_hs();
    int k = 0;
    @(negedge clk);
    while (!cfg_ready && k < 20) begin
      @(negedge clk);
      k++;
    end
    check("cfg_handshake", cfg_ready, 1);
    @(posedge clk);
    #1 cfg_valid = 1'b0;
  endtask

  task automatic start_layer(input int base, input int len, input int passes);
    logic [CW-1:0] ch;
    for (int p = 0; p < passes; p++) begin
      for (int c = 0; c < len; c++) begin
        ch = CW'((base + c) % NUM);
        iss_q.push_back({(c == 0), ch});
        exp_q.push_back({(c == 0), (c == len - 1), ch});
      end
    end
    layer_done = 0;
    cur_illegal = 0;
    @(posedge clk);
    #1;
    cfg_base   = CW'(base);
    cfg_len    = (CW+1)'(len);
    cfg_passes = PW'(passes);
    cfg_valid  = 1'b1;
    wait_hs();
  endtask

  task automatic wait_layer(input int budget);
    int k = 0;
    while (!layer_done && k < budget) begin
      @(posedge clk);
      k++;
    end
    check("layer_finished", layer_done, 1);
    check("beats_left", exp_q.size(), 0);
    check("issues_left", iss_q.size(), 0);
  endtask

  task automatic do_writes(input int n);
    repeat (n) begin
      @(posedge clk);
      #1 wr_valid = 1'b1;
    end
    @(posedge clk);
    #1 wr_valid = 1'b0;
  endtask

  task automatic end_layer_pulse(output logic nc);
    wr_layer_end = 1'b1;
    @(negedge clk);
    nc = w_next_chunk;
    @(posedge clk);
    #1 wr_layer_end = 1'b0;
  endtask

  task automatic random_writes(input int n);
    repeat (n) begin
      @(posedge clk);
      #1;
      wr_valid     = 1'($urandom_range(0, 1));
      wr_layer_end = ($urandom_range(0, 7) == 0);
    end
    @(posedge clk);
    #1;
    wr_valid     = 1'b0;
    wr_layer_end = 1'b0;
  endtask

`ifdef SDP_SEQ_CTRL_CHECK_EN
  task automatic bad_cfg(input int base, input int len, input int passes);
    int l0;
    l0 = n_load;
    cur_illegal = 1;
    @(posedge clk);
    #1;
    cfg_base   = CW'(base);
    cfg_len    = (CW+1)'(len);
    cfg_passes = PW'(passes);
    cfg_valid  = 1'b1;
    wait_hs();
    repeat (5) @(posedge clk);
    #1;
    check("bad_cfg_no_load", n_load - l0, 0);
    check("bad_cfg_stays_idle", cfg_ready, 1);
    cur_illegal = 0;
  endtask
`endif

  // ---------------- main sequence ----------------
  logic nc;
  int l0, i0, s0;

  initial begin
    rst = 1'b1;
    cfg_valid = 1'b0;
    cfg_base = '0;
    cfg_len = '0;
    cfg_passes = '0;
    wr_valid = 1'b0;
    wr_layer_end = 1'b0;
    rr_mode = 1;

    // reset state
    repeat (2) @(posedge clk);
    #1;
    check("rst_cfg_ready", cfg_ready, 1);
    check("rst_rd_valid", {rd_valid, rd_first, rd_last}, 3'b000);
    check("rst_done_err", {done, cfg_err}, 2'b00);
    check("rst_rp", {rp_load, rp_inc, w_next_chunk}, 3'b000);
    idle_code = dbg_state;
    @(posedge clk);
    #1 rst = 1'b0;

    // base 3, len 4, 2 passes, consumer always ready
    start_layer(3, 4, 2);
    check("state_busy", dbg_state != idle_code, 1);
    wait_layer(50);
    check("first_beat_latency", first_rv_cyc - hs_cyc, 2);
    check("done_cycle", done_cyc - hs_cyc, 9);

    // pointer wrap: 33, 34, 0, 1 from one load and three increments
    l0 = n_load;
    i0 = n_inc;
    start_layer(33, 4, 1);
    wait_layer(50);
    check("wrap_loads", n_load - l0, 1);
    check("wrap_incs", n_inc - i0, 3);

    // consumer stall of 3 cycles mid-pass
    start_layer(10, 6, 2);
    repeat (3) @(posedge clk);
    @(negedge clk);
    s0 = n_stall;
    rr_mode = 0;
    repeat (3) @(posedge clk);
    @(negedge clk);
    rr_mode = 1;
    @(posedge clk);
    #2;
    check("stall_cycles", n_stall - s0, 3);
    wait_layer(80);

    // write side: 30 words leaves a partial chunk, 27 words fills one
    do_writes(30);
    end_layer_pulse(nc);
    check("wnc_after_30", nc, 1);
    end_layer_pulse(nc);
    check("wnc_after_reset_wo", nc, 0);
    do_writes(27);
    end_layer_pulse(nc);
    check("wnc_after_27", nc, 0);

    // reset during pass 2
    start_layer(5, 3, 4);
    begin
      int k = 0;
      while (exp_q.size() > 8 && k < 100) begin
        @(posedge clk);
        k++;
      end
      check("reached_pass2", exp_q.size() <= 8, 1);
    end
    @(posedge clk);
    #2 rst = 1'b1;
    #1;
    check("midrst_rd", {rd_valid, rd_first, rd_last}, 3'b000);
    check("midrst_rp_done", {rp_load, rp_inc, done}, 3'b000);
    exp_q.delete();
    iss_q.delete();
    wo_m = 0;
    repeat (2) @(posedge clk);
    #1 rst = 1'b0;
    @(negedge clk);
    check("cfg_ready_after_rst", cfg_ready, 1);
    start_layer(0, 2, 1);
    wait_layer(40);

`ifdef SDP_SEQ_CTRL_CHECK_EN
    bad_cfg(2, 0, 1);
    bad_cfg(2, NUM + 1, 1);
    bad_cfg(2, 3, 0);
    start_layer(4, 2, 1);
    wait_layer(40);
`endif

    // randomized layers with concurrent write traffic
    rr_mode = 2;
    for (int t = 0; t < 8; t++) begin
      int b, l, p;
      b = $urandom_range(0, NUM - 1);
      l = $urandom_range(1, NUM);
      p = $urandom_range(1, 3);
      fork
        begin
          start_layer(b, l, p);
          wait_layer(3000);
        end
        random_writes($urandom_range(20, 80));
      join
    end
    rr_mode = 1;
    repeat (3) @(posedge clk);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule

// File: doc/sdp_seq_ctrl.md
SDP_SEQ_CTRL -- requirements
Module: sdp_seq_ctrl

Interface
REQ-001 SHALL have parameter NUM_CHUNKS, default 35, giving the number of chunks in the attached SDP buffer.
REQ-002 SHALL have parameter READ_WIDTH_MUL, default 27, giving the number of write words per chunk.
REQ-003 SHALL have parameter PASS_W, default 16, giving the width of the pass counter.
REQ-004 SHALL have ports, with CW = $clog2(NUM_CHUNKS):
- clk  in  1  sole clock.
- rst  in  1  asynchronous, active-high reset.
- cfg_valid  in  1  layer descriptor valid.
- cfg_ready  out  1  descriptor accepted when high with cfg_valid.
- cfg_base  in  CW  first chunk of the layer.
- cfg_len  in  CW+1  chunks per pass; legal range 1..NUM_CHUNKS.
- cfg_passes  in  PASS_W  passes over the chunks; legal range >=1.
- cfg_err  out  1  illegal-descriptor pulse.
- rp_load  out  1  to buffer.
- rp_load_val  out  CW  to buffer.
- rp_inc  out  1  to buffer.
- rd_valid  out  1  buffer rdata valid.
- rd_ready  in  1  consumer accepts.
- rd_first  out  1  beat is chunk 0 of a pass.
- rd_last  out  1  beat is the last chunk of a pass.
- done  out  1  layer complete pulse.
- wr_valid  in  1  producer word valid.
- wr_layer_end  in  1  producer finished layer.
- we  out  1  to buffer.
- w_next_chunk  out  1  to buffer.

Function
REQ-005 SHALL implement states IDLE, RUN and DRAIN.
REQ-006 SHALL hold cfg_ready = 1 only in IDLE; on handshake SHALL latch base/len/passes, clear chunk index ci and pass index pi, and enter RUN.
REQ-007 SHALL, in RUN, issue one read when issue = (!rd_valid || rd_ready); no read SHALL issue otherwise, and rp_load/rp_inc SHALL be 0 during stall.
REQ-008 SHALL issue ci=0 as rp_load=1 with rp_load_val=base, and issue ci>0 as rp_inc=1; the buffer applies the wrap at NUM_CHUNKS-1, and base+len > NUM_CHUNKS is legal.
REQ-009 SHALL register rd_valid/rd_first/rd_last one cycle after issue, aligned with buffer rdata; rd_valid SHALL clear on rd_ready with no new issue.
REQ-010 SHALL, at ci=len-1, reset ci to 0 and increment pi; after the issue with pi=passes-1 and ci=len-1, SHALL enter DRAIN.
REQ-011 SHALL, in DRAIN, pulse done for 1 cycle when the final beat is accepted (rd_valid && rd_ready), then return to IDLE; total first-cfg-to-first-rd_valid latency SHALL be 2 cycles.
REQ-012 SHALL drive we = wr_valid combinationally in every state, and track word offset wo modulo READ_WIDTH_MUL (increment on we, wrap to 0 after READ_WIDTH_MUL-1).
REQ-013 SHALL drive w_next_chunk = wr_layer_end && (wo' != 0), where wo' is wo after any same-cycle write; when w_next_chunk is high, wo SHALL go to 0.
REQ-014 SHALL keep the write side independent of the read FSM; simultaneous write and read traffic is legal.

Reset
REQ-015 SHALL, on rst, asynchronously set the state to IDLE, ci=pi=wo=0, and rd_valid, rd_first, rd_last, done and cfg_err to 0; rp_load, rp_inc and w_next_chunk SHALL read 0.
REQ-016 SHALL, on reset mid-layer, abandon the sequence with no done and resume with cfg_ready=1 in the first cycle after deassertion.

Configuration
REQ-017 SHALL, with SDP_SEQ_CTRL_CHECK_EN defined, accept a descriptor with cfg_len=0, cfg_len>NUM_CHUNKS or cfg_passes=0, pulse cfg_err for 1 cycle, stay in IDLE, and issue no reads.
REQ-018 SHALL, without SDP_SEQ_CTRL_CHECK_EN, tie cfg_err to 0 and leave illegal descriptors unchecked; behaviour for such descriptors is unspecified and unverified.

Verification
REQ-019 SHALL verify: base=3, len=4, passes=2, rd_ready=1 -> beats at cycles 2..9 (loads at ci=0), rd_first on beats 1 and 5, rd_last on beats 4 and 8, done on cycle 9.
REQ-020 SHALL verify: base=33, len=4 -> rp sequence 33, 34, 0, 1 via one load and 3 incs.
REQ-021 SHALL verify: rd_ready held low 3 cycles mid-pass -> rd_valid and the rdata chunk stay stable, no rp_inc, and the sequence resumes without loss.
REQ-022 SHALL verify: 30 writes then wr_layer_end -> w_next_chunk=1 and wo resets to 0; 27 writes then wr_layer_end -> w_next_chunk=0.
REQ-023 SHALL verify: rst asserted during pass 2 -> outputs clear immediately, no done, and cfg_ready=1 after release.
REQ-024 SHALL verify: with SDP_SEQ_CTRL_CHECK_EN defined, cfg_len=0 -> cfg_err pulse, no rp_load; without it, cfg_err stays 0.
